// File: rtl/scr1_ahb_arb.sv
// Two-master AHB-Lite arbiter: IMEM and DMEM bridges share one downstream port.
// Each master has an address-phase capture register so a NONSEQ issued while the
// downstream bus is busy is accepted and wait-stated instead of being lost.
module scr1_ahb_arb #(
  parameter int SCR1_ARB_RR    = 1,
  parameter int SCR1_AHB_WIDTH = 32
) (
  input  logic                      rst_n,
  input  logic                      clk,
  // IMEM master side
  input  logic [1:0]                imem_htrans,
  input  logic [3:0]                imem_hprot,
  input  logic [2:0]                imem_hburst,
  input  logic [2:0]                imem_hsize,
  input  logic                      imem_hmastlock,
  input  logic [SCR1_AHB_WIDTH-1:0] imem_haddr,
  output logic                      imem_hready,
  output logic [SCR1_AHB_WIDTH-1:0] imem_hrdata,
  output logic                      imem_hresp,
  // DMEM master side
  input  logic [1:0]                dmem_htrans,
  input  logic [3:0]                dmem_hprot,
  input  logic [2:0]                dmem_hburst,
  input  logic [2:0]                dmem_hsize,
  input  logic                      dmem_hmastlock,
  input  logic [SCR1_AHB_WIDTH-1:0] dmem_haddr,
  input  logic                      dmem_hwrite,
  input  logic [SCR1_AHB_WIDTH-1:0] dmem_hwdata,
  output logic                      dmem_hready,
  output logic [SCR1_AHB_WIDTH-1:0] dmem_hrdata,
  output logic                      dmem_hresp,
  // Downstream master port
  output logic [1:0]                htrans,
  output logic [3:0]                hprot,
  output logic [2:0]                hburst,
  output logic [2:0]                hsize,
  output logic                      hmastlock,
  output logic                      hwrite,
  output logic [SCR1_AHB_WIDTH-1:0] haddr,
  output logic [SCR1_AHB_WIDTH-1:0] hwdata,
  input  logic                      hready,
  input  logic [SCR1_AHB_WIDTH-1:0] hrdata,
  input  logic                      hresp
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic       HRESP_OKAY    = 1'b0;

  typedef enum logic {ST_IDLE, ST_DATA} state_t;
  typedef enum logic {M_IMEM, M_DMEM} master_t;

  state_t  state, state_nxt;
  master_t owner, owner_nxt, last_grant, grant_nxt, win;

  logic                      pend_i, pend_d;
  logic [SCR1_AHB_WIDTH-1:0] cap_i_addr, cap_d_addr;
  logic [3:0]                cap_i_prot, cap_d_prot;
  logic [2:0]                cap_i_size, cap_d_size;
  logic                      cap_i_lock, cap_d_lock, cap_d_write;

  logic [SCR1_AHB_WIDTH-1:0] iss_addr, sel_addr;
  logic [3:0]                iss_prot, sel_prot;
  logic [2:0]                iss_size, sel_size;
  logic                      iss_lock, sel_lock, iss_write, sel_write;

  logic data_i, data_d, done_i, done_d, wait_i, wait_d, any_wait, issue, advance;

  // Requested burst type is dropped: every transfer goes out as SINGLE.
  logic unused_hburst;
  assign unused_hburst = ^{imem_hburst, dmem_hburst};

  // Ownership decode and upstream responses.
  always_comb begin
    data_i      = (state == ST_DATA) && (owner == M_IMEM);
    data_d      = (state == ST_DATA) && (owner == M_DMEM);
    done_i      = data_i & hready;
    done_d      = data_d & hready;
    wait_i      = pend_i & ~data_i;
    wait_d      = pend_d & ~data_d;
    any_wait    = wait_i | wait_d;
    imem_hready = ~pend_i | done_i;
    dmem_hready = ~pend_d | done_d;
    imem_hresp  = data_i ? hresp : HRESP_OKAY;
    dmem_hresp  = data_d ? hresp : HRESP_OKAY;
    imem_hrdata = hrdata;
    dmem_hrdata = hrdata;
  end

  // Arbitration: a tie goes to the master not granted last (round-robin) or to DMEM.
  always_comb begin
    if (wait_i && wait_d)
      win = (SCR1_ARB_RR != 0 && last_grant == M_DMEM) ? M_IMEM : M_DMEM;
    else
      win = wait_d ? M_DMEM : M_IMEM;
    sel_addr  = (win == M_DMEM) ? cap_d_addr  : cap_i_addr;
    sel_prot  = (win == M_DMEM) ? cap_d_prot  : cap_i_prot;
    sel_size  = (win == M_DMEM) ? cap_d_size  : cap_i_size;
    sel_lock  = (win == M_DMEM) ? cap_d_lock  : cap_i_lock;
    sel_write = (win == M_DMEM) ? cap_d_write : 1'b0;
  end

  // Downstream FSM next state and address-phase drive.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    grant_nxt = last_grant;
    issue     = 1'b0;
    case (state)
      ST_IDLE: begin
        // The NONSEQ is driven even while hready is low, but only taken once it rises.
        issue = any_wait;
        if (any_wait && hready) begin
          state_nxt = ST_DATA;
          owner_nxt = win;
          grant_nxt = win;
        end
      end
      ST_DATA: begin
        if (hready) begin
          if (hresp != HRESP_OKAY) begin
            state_nxt = ST_IDLE;
          end else if (any_wait) begin
            issue     = 1'b1;
            owner_nxt = win;
            grant_nxt = win;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    advance   = issue & hready;
    htrans    = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
    haddr     = issue ? sel_addr  : iss_addr;
    hprot     = issue ? sel_prot  : iss_prot;
    hsize     = issue ? sel_size  : iss_size;
    hmastlock = issue ? sel_lock  : iss_lock;
    hwrite    = issue ? sel_write : iss_write;
    hburst    = 3'b000;
    hwdata    = data_d ? dmem_hwdata : '0;
  end

  // FSM state, owner, last grant and last-issued address phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= M_IMEM;
      last_grant <= M_IMEM;
      iss_addr   <= '0;
      iss_prot   <= '0;
      iss_size   <= '0;
      iss_lock   <= 1'b0;
      iss_write  <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= grant_nxt;
      if (advance) begin
        iss_addr  <= sel_addr;
        iss_prot  <= sel_prot;
        iss_size  <= sel_size;
        iss_lock  <= sel_lock;
        iss_write <= sel_write;
      end
    end
  end

  // IMEM capture stage; a new capture wins over completion of the previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_i     <= 1'b0;
      cap_i_addr <= '0;
      cap_i_prot <= '0;
      cap_i_size <= '0;
      cap_i_lock <= 1'b0;
    end else if (imem_htrans == HTRANS_NONSEQ && imem_hready) begin
      pend_i     <= 1'b1;
      cap_i_addr <= imem_haddr;
      cap_i_prot <= imem_hprot;
      cap_i_size <= imem_hsize;
      cap_i_lock <= imem_hmastlock;
    end else if (done_i) begin
      pend_i <= 1'b0;
    end
  end

  // DMEM capture stage; a new capture wins over completion of the previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_d      <= 1'b0;
      cap_d_addr  <= '0;
      cap_d_prot  <= '0;
      cap_d_size  <= '0;
      cap_d_lock  <= 1'b0;
      cap_d_write <= 1'b0;
    end else if (dmem_htrans == HTRANS_NONSEQ && dmem_hready) begin
      pend_d      <= 1'b1;
      cap_d_addr  <= dmem_haddr;
      cap_d_prot  <= dmem_hprot;
      cap_d_size  <= dmem_hsize;
      cap_d_lock  <= dmem_hmastlock;
      cap_d_write <= dmem_hwrite;
    end else if (done_d) begin
      pend_d <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scr1_ahb_arb.sv
// Cycle-table bench for scr1_ahb_arb with a round-robin DUT and a fixed-priority twin.
module tb_scr1_ahb_arb;
  localparam int W = 32;
  localparam logic [1:0] N = 2'b10;
  localparam logic [1:0] I = 2'b00;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]   imem_htrans, dmem_htrans;
  logic [3:0]   imem_hprot, dmem_hprot;
  logic [2:0]   imem_hburst, dmem_hburst, imem_hsize, dmem_hsize;
  logic         imem_hmastlock, dmem_hmastlock, dmem_hwrite;
  logic [W-1:0] imem_haddr, dmem_haddr, dmem_hwdata;
  logic         hready, hresp;
  logic [W-1:0] hrdata;

  logic         imem_hready, imem_hresp, dmem_hready, dmem_hresp;
  logic [W-1:0] imem_hrdata, dmem_hrdata;
  logic [1:0]   htrans;
  logic [3:0]   hprot;
  logic [2:0]   hburst, hsize;
  logic         hmastlock, hwrite;
  logic [W-1:0] haddr, hwdata;

  logic         fp_imem_hready, fp_imem_hresp, fp_dmem_hready, fp_dmem_hresp;
  logic [W-1:0] fp_imem_hrdata, fp_dmem_hrdata;
  logic [1:0]   fp_htrans;
  logic [3:0]   fp_hprot;
  logic [2:0]   fp_hburst, fp_hsize;
  logic         fp_hmastlock, fp_hwrite;
  logic [W-1:0] fp_haddr, fp_hwdata;

  scr1_ahb_arb #(.SCR1_ARB_RR(1), .SCR1_AHB_WIDTH(W)) u_dut (
    .rst_n(rst_n), .clk(clk),
    .imem_htrans(imem_htrans), .imem_hprot(imem_hprot), .imem_hburst(imem_hburst),
    .imem_hsize(imem_hsize), .imem_hmastlock(imem_hmastlock), .imem_haddr(imem_haddr),
    .imem_hready(imem_hready), .imem_hrdata(imem_hrdata), .imem_hresp(imem_hresp),
    .dmem_htrans(dmem_htrans), .dmem_hprot(dmem_hprot), .dmem_hburst(dmem_hburst),
    .dmem_hsize(dmem_hsize), .dmem_hmastlock(dmem_hmastlock), .dmem_haddr(dmem_haddr),
    .dmem_hwrite(dmem_hwrite), .dmem_hwdata(dmem_hwdata),
    .dmem_hready(dmem_hready), .dmem_hrdata(dmem_hrdata), .dmem_hresp(dmem_hresp),
    .htrans(htrans), .hprot(hprot), .hburst(hburst), .hsize(hsize),
    .hmastlock(hmastlock), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
    .hready(hready), .hrdata(hrdata), .hresp(hresp)
  );

  scr1_ahb_arb #(.SCR1_ARB_RR(0), .SCR1_AHB_WIDTH(W)) u_fp (
    .rst_n(rst_n), .clk(clk),
    .imem_htrans(imem_htrans), .imem_hprot(imem_hprot), .imem_hburst(imem_hburst),
    .imem_hsize(imem_hsize), .imem_hmastlock(imem_hmastlock), .imem_haddr(imem_haddr),
    .imem_hready(fp_imem_hready), .imem_hrdata(fp_imem_hrdata), .imem_hresp(fp_imem_hresp),
    .dmem_htrans(dmem_htrans), .dmem_hprot(dmem_hprot), .dmem_hburst(dmem_hburst),
    .dmem_hsize(dmem_hsize), .dmem_hmastlock(dmem_hmastlock), .dmem_haddr(dmem_haddr),
    .dmem_hwrite(dmem_hwrite), .dmem_hwdata(dmem_hwdata),
    .dmem_hready(fp_dmem_hready), .dmem_hrdata(fp_dmem_hrdata), .dmem_hresp(fp_dmem_hresp),
    .htrans(fp_htrans), .hprot(fp_hprot), .hburst(fp_hburst), .hsize(fp_hsize),
    .hmastlock(fp_hmastlock), .hwrite(fp_hwrite), .haddr(fp_haddr), .hwdata(fp_hwdata),
    .hready(hready), .hrdata(hrdata), .hresp(hresp)
  );

  typedef struct {
    logic [1:0] it;  logic [W-1:0] ia;
    logic [1:0] dt;  logic [W-1:0] da;
    logic dw;        logic [W-1:0] wd;
    logic rdy;       logic rsp;      logic [W-1:0] rd;
    logic [1:0] eht; logic [W-1:0] eha; logic ehw; logic [W-1:0] ehwd;
    logic eir;       logic eie;      logic edr;      logic ede;
    logic fpchk;     logic [W-1:0] efpa;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic add(input logic [1:0] it, input logic [W-1:0] ia, input logic [1:0] dt,
                     input logic [W-1:0] da, input logic dw, input logic [W-1:0] wd,
                     input logic rdy, input logic rsp, input logic [W-1:0] rd,
                     input logic [1:0] eht, input logic [W-1:0] eha, input logic ehw,
                     input logic [W-1:0] ehwd, input logic eir, input logic eie,
                     input logic edr, input logic ede);
    vec_t v;
    v = '{it, ia, dt, da, dw, wd, rdy, rsp, rd, eht, eha, ehw, ehwd, eir, eie, edr, ede,
          1'b0, '0};
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    imem_htrans = v.it; imem_haddr = v.ia;
    dmem_htrans = v.dt; dmem_haddr = v.da; dmem_hwrite = v.dw; dmem_hwdata = v.wd;
    hready = v.rdy; hresp = v.rsp; hrdata = v.rd;
  endtask

  initial begin
    vec_t e;
    vec_t idle;
    rst_n = 1'b0;
    imem_hprot = 4'h2; imem_hsize = 3'd2; imem_hmastlock = 1'b0; imem_hburst = 3'b011;
    dmem_hprot = 4'h3; dmem_hsize = 3'd2; dmem_hmastlock = 1'b0; dmem_hburst = 3'b101;
    idle = '{I, '0, I, '0, 1'b0, '0, 1'b1, 1'b0, '0, I, '0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0,
             1'b0, '0};
    drive(idle);

    // it ia dt da dw wd rdy rsp rd | htrans haddr hwrite hwdata ir ie dr de
    add(N, 'h100, I, 0, 0, 0, 1, 0, 0,            I, 'h000, 0, 0, 1, 0, 1, 0); // c0
    add(I, 0, I, 0, 0, 0, 1, 0, 0,                N, 'h100, 0, 0, 0, 0, 1, 0); // c1
    add(I, 0, I, 0, 0, 0, 1, 0, 'hDEADBEEF,       I, 'h100, 0, 0, 1, 0, 1, 0); // c2
    add(I, 0, I, 0, 0, 0, 1, 0, 0,                I, 'h100, 0, 0, 1, 0, 1, 0); // c3
    add(N, 'h200, N, 'h300, 1, 0, 1, 0, 0,        I, 'h100, 0, 0, 1, 0, 1, 0); // c4
    add(I, 0, I, 0, 1, 'h5A5A5A5A, 1, 0, 0,       N, 'h300, 1, 0, 0, 0, 0, 0); // c5
    add(I, 0, I, 0, 1, 'h5A5A5A5A, 1, 0, 0,       N, 'h200, 0, 'h5A5A5A5A, 0, 0, 1, 0); // c6
    add(I, 0, I, 0, 0, 0, 1, 0, 'h12345678,       I, 'h200, 0, 0, 1, 0, 1, 0); // c7
    add(I, 0, I, 0, 0, 0, 1, 0, 0,                I, 'h200, 0, 0, 1, 0, 1, 0); // c8
    add(N, 'h500, N, 'h400, 0, 0, 1, 0, 0,        I, 'h200, 0, 0, 1, 0, 1, 0); // c9
    add(I, 0, I, 0, 0, 0, 1, 0, 0,                N, 'h400, 0, 0, 0, 0, 0, 0); // c10
    add(I, 0, I, 0, 0, 0, 0, 0, 0,                I, 'h400, 0, 0, 0, 0, 0, 0); // c11
    add(I, 0, I, 0, 0, 0, 0, 0, 0,                I, 'h400, 0, 0, 0, 0, 0, 0); // c12
    add(I, 0, I, 0, 0, 0, 0, 0, 0,                I, 'h400, 0, 0, 0, 0, 0, 0); // c13
    add(I, 0, I, 0, 0, 0, 1, 0, 'hCAFEF00D,       N, 'h500, 0, 0, 0, 0, 1, 0); // c14
    add(I, 0, I, 0, 0, 0, 1, 0, 0,                I, 'h500, 0, 0, 1, 0, 1, 0); // c15
    add(N, 'h600, I, 0, 0, 0, 1, 0, 0,            I, 'h500, 0, 0, 1, 0, 1, 0); // c16
    add(I, 0, N, 'h700, 0, 0, 1, 0, 0,            N, 'h600, 0, 0, 0, 0, 1, 0); // c17
    add(I, 0, I, 0, 0, 0, 0, 1, 0,                I, 'h600, 0, 0, 0, 1, 0, 0); // c18
    add(I, 0, I, 0, 0, 0, 1, 1, 0,                I, 'h600, 0, 0, 1, 1, 0, 0); // c19
    add(I, 0, I, 0, 0, 0, 1, 0, 0,                N, 'h700, 0, 0, 1, 0, 0, 0); // c20
    add(I, 0, I, 0, 0, 0, 1, 0, 0,                I, 'h700, 0, 0, 1, 0, 1, 0); // c21
    add(N, 'h800, N, 'h900, 0, 0, 1, 0, 0,        I, 'h700, 0, 0, 1, 0, 1, 0); // c22
    add(I, 0, I, 0, 0, 0, 1, 0, 0,                N, 'h800, 0, 0, 0, 0, 0, 0); // c23
    add(N, 'h804, I, 0, 0, 0, 1, 0, 0,            N, 'h900, 0, 0, 1, 0, 0, 0); // c24
    add(I, 0, N, 'h904, 0, 0, 1, 0, 0,            N, 'h804, 0, 0, 0, 0, 1, 0); // c25
    add(I, 0, I, 0, 0, 0, 1, 0, 0,                N, 'h904, 0, 0, 1, 0, 0, 0); // c26
    add(I, 0, I, 0, 0, 0, 1, 0, 0,                I, 'h904, 0, 0, 1, 0, 1, 0); // c27
    add(I, 0, I, 0, 0, 0, 1, 0, 0,                I, 'h904, 0, 0, 1, 0, 1, 0); // c28
    // Tie with last grant DMEM: round-robin picks IMEM, fixed priority picks DMEM.
    tbl[23].fpchk = 1'b1;
    tbl[23].efpa  = 'h900;

    #12;
    chk("reset_state", {htrans, haddr, hwrite, hwdata, imem_hready, imem_hresp,
                        dmem_hready, dmem_hresp},
        {2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i]);
      sb.push_back(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("cycle%0d", i),
          {htrans, haddr, hwrite, hwdata, imem_hready, imem_hresp, dmem_hready, dmem_hresp,
           hburst, imem_hrdata, dmem_hrdata},
          {e.eht, e.eha, e.ehw, e.ehwd, e.eir, e.eie, e.edr, e.ede, 3'b000, e.rd, e.rd});
      if (e.fpchk)
        chk($sformatf("fixed_prio_cycle%0d", i), {fp_htrans, fp_haddr}, {N, e.efpa});
    end

    // Reset asserted while a DMEM write sits in a wait-stated data phase.
    @(posedge clk); #1;
    drive(idle);
    dmem_htrans = N; dmem_haddr = 'hA00; dmem_hwrite = 1'b1;
    @(posedge clk); #1;
    dmem_htrans = I; dmem_hwdata = 'h11112222;
    @(negedge clk);
    chk("rst_seq_issue", {htrans, haddr, hwrite}, {N, 32'hA00, 1'b1});
    @(posedge clk); #1;
    hready = 1'b0;
    @(negedge clk);
    chk("rst_seq_data", {dmem_hready, hwdata, htrans}, {1'b0, 32'h11112222, I});
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {htrans, haddr, hwrite, hwdata, imem_hready, dmem_hready, dmem_hresp},
        {I, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    hready = 1'b1;
    dmem_hwdata = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d", k), {htrans, haddr, imem_hready, dmem_hready},
          {I, 32'h0, 1'b1, 1'b1});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/scr1_ahb_arb.md
# scr1_ahb_arb

Two-master AHB-Lite arbiter that shares a single downstream AHB master port between the instruction-fetch bridge (IMEM side) and the data bridge (DMEM side). Each upstream side gets an address-phase capture stage, so a master that issues NONSEQ while the bus is busy is accepted and wait-stated rather than dropped. The block sits between the core's IMEM/DMEM AHB bridges and the system interconnect.

## Interface

Parameters:
- SCR1_ARB_RR, default 1: 1 = round-robin between masters; 0 = fixed priority, DMEM always wins a tie.

Address width `SCR1_AHB_WIDTH` comes from `scr1_ahb.svh`.

Ports (clock and reset first):
- rst_n  in  1  asynchronous active-low reset
- clk  in  1  single clock; all state on posedge clk
- imem_htrans  in  2  IMEM master transfer type
- imem_hprot/hburst/hsize/hmastlock  in  4/3/3/1  IMEM address-phase control
- imem_haddr  in  SCR1_AHB_WIDTH  IMEM address
- imem_hready  out  1  ready returned to IMEM master
- imem_hrdata  out  SCR1_AHB_WIDTH  read data to IMEM master
- imem_hresp  out  1  response to IMEM master
- dmem_htrans, dmem_hprot/hburst/hsize/hmastlock, dmem_haddr  in  as IMEM  DMEM address phase
- dmem_hwrite  in  1  DMEM write flag
- dmem_hwdata  in  SCR1_AHB_WIDTH  DMEM write data, held by the master through its data phase
- dmem_hready/hrdata/hresp  out  1/W/1  DMEM responses
- htrans/hprot/hburst/hsize/hmastlock/hwrite  out  2/4/3/3/1/1  downstream address phase
- haddr, hwdata  out  SCR1_AHB_WIDTH  downstream address and write data
- hready, hrdata, hresp  in  1/W/1  downstream slave response

## Operation

**Capture stage (per master m)**
- Register pend_m plus captured addr, ctrl and hwrite.
- pend_m sets when htrans_m == NONSEQ and hready_m == 1.
- pend_m clears when m's downstream data phase completes with hready == 1.
- If a set and a clear happen in the same cycle, set wins and the new address is loaded.
- NONSEQ presented while hready_m == 0 is ignored; the master holds it.

**Upstream response**
- hready_m = ~pend_m | (state == DATA & owner == m & hready).
- hresp_m = (state == DATA & owner == m) ? hresp : OKAY.
- hrdata_m = hrdata, passed through unregistered.

**Downstream FSM: IDLE, DATA; register owner ∈ {IMEM, DMEM}**
- Waiting_m = pend_m & ~(state == DATA & owner == m).
- Issue condition: (IDLE, or DATA with hready & hresp == OKAY) and any waiting_m.
  - Drive htrans = NONSEQ and the winner's captured haddr/ctrl.
  - owner <= winner; state <= DATA.
- IDLE with nothing waiting: htrans = IDLE and state stays IDLE.
- DATA & hready & nothing waiting: go to IDLE.
- DATA with hresp == ERROR: htrans = IDLE in both error-response cycles; go to IDLE on the hready cycle.
- Issue in IDLE also requires hready == 1; otherwise hold the drive and do not advance.

**Arbitration**
- Round-robin: on a tie, grant the master that is not last_grant. last_grant updates on every issue; reset value is IMEM, so DMEM wins the first tie.
- Fixed priority (SCR1_ARB_RR = 0): DMEM wins every tie.

**Output rules**
- hwdata = dmem_hwdata when state == DATA & owner == DMEM, else 0.
- haddr/ctrl show the last issued values while htrans == IDLE.
- hburst = SINGLE whatever the master requested.

## Timing

- Reset values (asynchronous):
  - state IDLE, pend_i = pend_d = 0, last_grant IMEM, captured registers 0.
  - htrans IDLE, haddr 0, hwrite 0.
  - imem_hready = dmem_hready = 1, both hresp OKAY.
- Reset mid-transfer discards every pending and issued transfer; no completion is signalled.
- Latency, idle bus:
  - NONSEQ at master in cycle 0.
  - Downstream NONSEQ in cycle 1.
  - Downstream data phase in cycle 2; master sees hready_m = 1 with data in cycle 2 with a zero-wait slave.
- One extra wait state versus a direct connection.
- Back-to-back transfers: the next downstream address is issued in the completing data-phase cycle, giving a throughput of one transfer per cycle when alternating masters.
- Downstream wait states extend the owner's hready_m = 0 cycle for cycle.
- The non-owner waits until the owner's data phase completes.

## Test plan

- Single IMEM read, addr 0x100, zero-wait slave returns 0xDEADBEEF:
  - downstream NONSEQ at cycle 1;
  - imem_hready high with hrdata 0xDEADBEEF at cycle 2.
- Simultaneous IMEM 0x200 and DMEM write 0x300 / 0x5A5A5A5A, with SCR1_ARB_RR = 1:
  - DMEM issued first, IMEM issued in DMEM's completing cycle;
  - hwdata = 0x5A5A5A5A during the DMEM data phase;
  - IMEM hready is held low until its own completion.
- Both masters stream continuously:
  - grants alternate D, I, D, I;
  - with SCR1_ARB_RR = 0, DMEM is issued every time it is waiting.
- Slave inserts 3 wait states on a DMEM read:
  - dmem_hready stays low for 3 extra cycles;
  - the IMEM pending transfer is not issued until the completion cycle.
- Two-cycle ERROR on an IMEM transfer while DMEM is pending:
  - imem_hresp = 1 for both cycles;
  - htrans IDLE in both cycles;
  - DMEM is issued from IDLE on the next cycle.
- Assert rst_n while a DMEM transfer is in its data phase:
  - immediately htrans IDLE, both hready 1, pend cleared;
  - no spurious completion after reset release.
